// File: rtl/stage3_writeback_pkg.sv
// Shared definitions for the write-back/commit stage.
//   - mblock_s3 write-back mode encodings (MB3_*)
//   - commit-stage state encoding
//   - default sequential PC increment
package stage3_writeback_pkg;

  localparam logic [2:0] MB3_NOP    = 3'd0;
  localparam logic [2:0] MB3_ST_VW  = 3'd1;
  localparam logic [2:0] MB3_ST_VRW = 3'd2;
  localparam logic [2:0] MB3_JMP    = 3'd3;
  localparam logic [2:0] MB3_JZ     = 3'd4;
  localparam logic [2:0] MB3_JNZ    = 3'd5;
  localparam logic [2:0] MB3_OUT    = 3'd6;
  localparam logic [2:0] MB3_HALT   = 3'd7;

  localparam logic [15:0] PC_STEP_DEFAULT = 16'd4;

  typedef enum logic [1:0] {
    StIdle,
    StCommit,
    StIo,
    StHalt
  } state_e;

endpackage

// File: rtl/stage3_pc_next.sv
// Combinational next-PC selection for one write-back mode.
// Ports:
//   pc          - current program counter
//   mode        - mblock_s3 write-back mode
//   alu_is_zero - ALU zero flag qualifying JZ/JNZ
//   vw_value    - jump target (already truncated to 16 bits)
//   next_pc     - PC to commit at the accept edge
// OUT and HALT leave the PC untouched; OUT advances it later, once the
// IO handshake completes.
module stage3_pc_next
  import stage3_writeback_pkg::*;
#(
  parameter logic [15:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [15:0] pc,
  input  logic [2:0]  mode,
  input  logic        alu_is_zero,
  input  logic [15:0] vw_value,
  output logic [15:0] next_pc
);

  logic [15:0] seq_pc;

  // Modulo 2^16 wrap is intended.
  assign seq_pc = pc + PC_STEP;

  always_comb begin
    next_pc = seq_pc;
    case (mode)
      MB3_JMP:  next_pc = vw_value;
      MB3_JZ:   next_pc = alu_is_zero ? vw_value : seq_pc;
      MB3_JNZ:  next_pc = alu_is_zero ? seq_pc : vw_value;
      MB3_OUT,
      MB3_HALT: next_pc = pc;
      default:  next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/stage3_writeback.sv
// Commit stage downstream of STAGE2: performs the RAM store, jump/branch,
// output-port write or halt selected by mblock_s3, and owns the PC.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   in_valid / in_ready     - STAGE2 result handshake (ready only in idle)
//   mblock_s3               - write-back mode, sampled on accept
//   vw_value, vrw_value     - ALU result / resolved rw operand
//   ram_address, alu_is_zero- effective address / ALU zero flag
//   pc                      - current program counter
//   ram_we/ram_waddr/ram_wdata - one-cycle RAM write strobe plus held addr/data
//   io_valid/io_ready/io_port/io_data - output-port handshake
//   instr_done              - one-cycle pulse per committed instruction
//   halted                  - high while halted
// All outputs come straight from flops.
module stage3_writeback
  import stage3_writeback_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'd0,
  parameter logic [15:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  mblock_s3,
  input  logic [31:0] vw_value,
  input  logic [31:0] vrw_value,
  input  logic [15:0] ram_address,
  input  logic        alu_is_zero,
  output logic [15:0] pc,
  output logic        ram_we,
  output logic [15:0] ram_waddr,
  output logic [31:0] ram_wdata,
  output logic        io_valid,
  input  logic        io_ready,
  output logic [7:0]  io_port,
  output logic [31:0] io_data,
  output logic        instr_done,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        in_ready_q, in_ready_d;
  logic        ram_we_q, ram_we_d;
  logic [15:0] ram_waddr_q, ram_waddr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        io_valid_q, io_valid_d;
  logic [7:0]  io_port_q, io_port_d;
  logic [31:0] io_data_q, io_data_d;
  logic        instr_done_q, instr_done_d;
  logic        halted_q, halted_d;
  logic [15:0] next_pc;

  stage3_pc_next #(
    .PC_STEP (PC_STEP)
  ) u_pc_next (
    .pc          (pc_q),
    .mode        (mblock_s3),
    .alu_is_zero (alu_is_zero),
    .vw_value    (vw_value[15:0]),
    .next_pc     (next_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ram_we_d     = 1'b0;
    ram_waddr_d  = ram_waddr_q;
    ram_wdata_d  = ram_wdata_q;
    io_port_d    = io_port_q;
    io_data_d    = io_data_q;
    instr_done_d = 1'b0;

    case (state_q)
      StIdle: begin
        // in_ready is high exactly in idle, so in_valid alone means accept.
        if (in_valid) begin
          pc_d = next_pc;
          case (mblock_s3)
            MB3_OUT: begin
              state_d   = StIo;
              io_port_d = ram_address[7:0];
              io_data_d = vw_value;
            end
            MB3_HALT: state_d = StHalt;
            default: begin
              state_d      = StCommit;
              instr_done_d = 1'b1;
              if (mblock_s3 == MB3_ST_VW || mblock_s3 == MB3_ST_VRW) begin
                ram_we_d    = 1'b1;
                ram_waddr_d = ram_address;
                ram_wdata_d = (mblock_s3 == MB3_ST_VW) ? vw_value : vrw_value;
              end
            end
          endcase
        end
      end
      StCommit: state_d = StIdle;
      StIo: begin
        if (io_ready) begin
          pc_d         = pc_q + PC_STEP;
          state_d      = StCommit;
          instr_done_d = 1'b1;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase

    // Level outputs are registered decodes of the next state.
    in_ready_d = (state_d == StIdle);
    io_valid_d = (state_d == StIo);
    halted_d   = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= PC_RESET;
      in_ready_q   <= 1'b1;
      ram_we_q     <= 1'b0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
      io_valid_q   <= 1'b0;
      io_port_q    <= '0;
      io_data_q    <= '0;
      instr_done_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      in_ready_q   <= in_ready_d;
      ram_we_q     <= ram_we_d;
      ram_waddr_q  <= ram_waddr_d;
      ram_wdata_q  <= ram_wdata_d;
      io_valid_q   <= io_valid_d;
      io_port_q    <= io_port_d;
      io_data_q    <= io_data_d;
      instr_done_q <= instr_done_d;
      halted_q     <= halted_d;
    end
  end

  assign pc         = pc_q;
  assign in_ready   = in_ready_q;
  assign ram_we     = ram_we_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
  assign io_valid   = io_valid_q;
  assign io_port    = io_port_q;
  assign io_data    = io_data_q;
  assign instr_done = instr_done_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_stage3_writeback.sv
module tb_stage3_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  mblock_s3;
  logic [31:0] vw_value;
  logic [31:0] vrw_value;
  logic [15:0] ram_address;
  logic        alu_is_zero;
  logic [15:0] pc;
  logic        ram_we;
  logic [15:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic        io_valid;
  logic        io_ready;
  logic [7:0]  io_port;
  logic [31:0] io_data;
  logic        instr_done;
  logic        halted;

  stage3_writeback #(
    .PC_RESET (16'd0),
    .PC_STEP  (16'd4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mblock_s3   (mblock_s3),
    .vw_value    (vw_value),
    .vrw_value   (vrw_value),
    .ram_address (ram_address),
    .alu_is_zero (alu_is_zero),
    .pc          (pc),
    .ram_we      (ram_we),
    .ram_waddr   (ram_waddr),
    .ram_wdata   (ram_wdata),
    .io_valid    (io_valid),
    .io_ready    (io_ready),
    .io_port     (io_port),
    .io_data     (io_data),
    .instr_done  (instr_done),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural reference state.
  logic [15:0] m_pc;
  logic [15:0] m_waddr;
  logic [31:0] m_wdata;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] vw;
    logic [31:0] vrw;
    logic [15:0] addr;
    logic        z;
    logic [15:0] exp_pc;
    logic        exp_we;
    logic [15:0] exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_waddr", 32'(ram_waddr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst_io_valid", 32'(io_valid), 32'd0);
    chk("rst_io_port", 32'(io_port), 32'd0);
    chk("rst_io_data", io_data, 32'd0);
    chk("rst_instr_done", 32'(instr_done), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    io_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_values();
    m_pc    = 16'd0;
    m_waddr = 16'd0;
    m_wdata = 32'd0;
  endtask

  task automatic drive_accept(input logic [2:0] mode, input logic [31:0] vw,
                              input logic [31:0] vrw, input logic [15:0] addr,
                              input logic z);
    mblock_s3   = mode;
    vw_value    = vw;
    vrw_value   = vrw;
    ram_address = addr;
    alu_is_zero = z;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid    = 1'b0;
    vw_value    = $urandom;
    vrw_value   = $urandom;
    ram_address = 16'($urandom);
    mblock_s3   = 3'($urandom);
  endtask

  task automatic chk_back_idle();
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_instr_done", 32'(instr_done), 32'd0);
    chk("idle_ram_we", 32'(ram_we), 32'd0);
    chk("idle_pc", 32'(pc), 32'(m_pc));
  endtask

  // Modes 0-5 against the reference model.
  task automatic run_simple(input logic [2:0] mode, input logic [31:0] vw,
                            input logic [31:0] vrw, input logic [15:0] addr,
                            input logic z);
    logic we;
    we = (mode == 3'd1) || (mode == 3'd2);
    if (we) begin
      m_waddr = addr;
      m_wdata = (mode == 3'd1) ? vw : vrw;
    end
    if (mode == 3'd3) m_pc = vw[15:0];
    else if (mode == 3'd4 && z) m_pc = vw[15:0];
    else if (mode == 3'd5 && !z) m_pc = vw[15:0];
    else m_pc = m_pc + 16'd4;
    io_ready = 1'($urandom);  // must be ignored outside IO
    drive_accept(mode, vw, vrw, addr, z);
    chk("cm_pc", 32'(pc), 32'(m_pc));
    chk("cm_instr_done", 32'(instr_done), 32'd1);
    chk("cm_ram_we", 32'(ram_we), 32'(we));
    chk("cm_ram_waddr", 32'(ram_waddr), 32'(m_waddr));
    chk("cm_ram_wdata", ram_wdata, m_wdata);
    chk("cm_in_ready", 32'(in_ready), 32'd0);
    chk("cm_io_valid", 32'(io_valid), 32'd0);
    chk("cm_halted", 32'(halted), 32'd0);
    chk_back_idle();
  endtask

  task automatic run_io(input logic [31:0] vw, input logic [15:0] addr, input int wait_cycles);
    logic [15:0] old_pc;
    old_pc   = m_pc;
    io_ready = 1'($urandom);
    drive_accept(3'd6, vw, 32'($urandom), addr, 1'($urandom));
    io_ready = 1'b0;
    for (int w = 0; w <= wait_cycles; w++) begin
      chk("io_valid", 32'(io_valid), 32'd1);
      chk("io_port", 32'(io_port), 32'(addr[7:0]));
      chk("io_data", io_data, vw);
      chk("io_pc_held", 32'(pc), 32'(old_pc));
      chk("io_in_ready", 32'(in_ready), 32'd0);
      chk("io_instr_done", 32'(instr_done), 32'd0);
      chk("io_ram_we", 32'(ram_we), 32'd0);
      if (w == wait_cycles) io_ready = 1'b1;
      @(negedge clk);
    end
    io_ready = 1'b0;
    m_pc = old_pc + 16'd4;
    chk("iodone_io_valid", 32'(io_valid), 32'd0);
    chk("iodone_pc", 32'(pc), 32'(m_pc));
    chk("iodone_instr_done", 32'(instr_done), 32'd1);
    chk("iodone_ram_we", 32'(ram_we), 32'd0);
    chk("iodone_ram_waddr", 32'(ram_waddr), 32'(m_waddr));
    chk("iodone_ram_wdata", ram_wdata, m_wdata);
    chk_back_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    io_ready    = 1'b0;
    mblock_s3   = 3'd0;
    vw_value    = 32'd0;
    vrw_value   = 32'd0;
    ram_address = 16'd0;
    alu_is_zero = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed table, applied back to back from PC 0.
    vecs[0]  = '{3'd1, 32'd1099,       32'd0,  16'd20,    1'b0, 16'd4,      1'b1, 16'd20,   32'd1099};
    vecs[1]  = '{3'd3, 32'h0001_0054,  32'd0,  16'h1234,  1'b0, 16'h0054,   1'b0, 16'd20,   32'd1099};
    vecs[2]  = '{3'd4, 32'h0001_0200,  32'd0,  16'd0,     1'b1, 16'h0200,   1'b0, 16'd20,   32'd1099};
    vecs[3]  = '{3'd3, 32'd84,         32'd0,  16'd0,     1'b0, 16'd84,     1'b0, 16'd20,   32'd1099};
    vecs[4]  = '{3'd4, 32'h0001_0200,  32'd0,  16'd0,     1'b0, 16'd88,     1'b0, 16'd20,   32'd1099};
    vecs[5]  = '{3'd5, 32'h0001_0200,  32'd0,  16'd0,     1'b0, 16'h0200,   1'b0, 16'd20,   32'd1099};
    vecs[6]  = '{3'd5, 32'h0000_0300,  32'd0,  16'd0,     1'b1, 16'h0204,   1'b0, 16'd20,   32'd1099};
    vecs[7]  = '{3'd3, 32'hABCD_FFFC,  32'd0,  16'd0,     1'b0, 16'hFFFC,   1'b0, 16'd20,   32'd1099};
    vecs[8]  = '{3'd0, 32'd5,          32'd0,  16'd0,     1'b1, 16'h0000,   1'b0, 16'd20,   32'd1099};
    vecs[9]  = '{3'd2, 32'd5,          32'd99, 16'd1000,  1'b0, 16'd4,      1'b1, 16'd1000, 32'd99};
    vecs[10] = '{3'd0, 32'd7,          32'd1,  16'd3,     1'b0, 16'd8,      1'b0, 16'd1000, 32'd99};

    for (int i = 0; i < 11; i++) begin
      drive_accept(vecs[i].mode, vecs[i].vw, vecs[i].vrw, vecs[i].addr, vecs[i].z);
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_ram_waddr", i), 32'(ram_waddr), 32'(vecs[i].exp_waddr));
      chk($sformatf("vec%0d_ram_wdata", i), ram_wdata, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_instr_done", i), 32'(instr_done), 32'd1);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_ready_again", i), 32'(in_ready), 32'd1);
      chk($sformatf("vec%0d_we_pulse", i), 32'(ram_we), 32'd0);
      chk($sformatf("vec%0d_done_pulse", i), 32'(instr_done), 32'd0);
    end
    m_pc    = 16'd8;
    m_waddr = 16'd1000;
    m_wdata = 32'd99;

    // OUT with io_ready held low for three cycles.
    run_io(32'd42, 16'h0107, 3);

    // Randomized instruction stream against the reference model.
    for (int i = 0; i < 300; i++) begin
      int idle;
      logic [2:0] mode;
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        in_valid    = 1'b0;
        mblock_s3   = 3'($urandom);
        vw_value    = $urandom;
        io_ready    = 1'($urandom);
        @(negedge clk);
        chk("gap_pc", 32'(pc), 32'(m_pc));
        chk("gap_in_ready", 32'(in_ready), 32'd1);
        chk("gap_instr_done", 32'(instr_done), 32'd0);
        chk("gap_ram_we", 32'(ram_we), 32'd0);
      end
      mode = 3'($urandom_range(0, 6));
      if (mode == 3'd6) run_io($urandom, 16'($urandom), $urandom_range(0, 3));
      else run_simple(mode, $urandom, $urandom, 16'($urandom), 1'($urandom));
    end

    // HALT is sticky until reset.
    do_reset();
    run_simple(3'd3, 32'h0000_1230, 32'd0, 16'd0, 1'b0);
    drive_accept(3'd7, 32'h0000_5555, 32'd0, 16'd9, 1'b1);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_in_ready", 32'(in_ready), 32'd0);
    chk("halt_pc", 32'(pc), 32'h1230);
    chk("halt_instr_done", 32'(instr_done), 32'd0);
    for (int k = 0; k < 5; k++) begin
      mblock_s3   = 3'($urandom_range(0, 3));
      vw_value    = $urandom;
      ram_address = 16'($urandom);
      in_valid    = 1'b1;
      io_ready    = 1'($urandom);
      @(negedge clk);
      chk("halt_hold_halted", 32'(halted), 32'd1);
      chk("halt_hold_in_ready", 32'(in_ready), 32'd0);
      chk("halt_hold_pc", 32'(pc), 32'h1230);
      chk("halt_hold_ram_we", 32'(ram_we), 32'd0);
      chk("halt_hold_instr_done", 32'(instr_done), 32'd0);
    end
    in_valid = 1'b0;
    do_reset();

    // Reset during IO, with in_valid and io_ready also high on that edge.
    run_simple(3'd1, 32'hDEAD_BEEF, 32'd0, 16'd77, 1'b0);
    drive_accept(3'd6, 32'd123, 32'd0, 16'h0042, 1'b0);
    io_ready = 1'b0;
    chk("rio_io_valid_before", 32'(io_valid), 32'd1);
    reset       = 1'b1;
    in_valid    = 1'b1;
    mblock_s3   = 3'd1;
    ram_address = 16'd55;
    io_ready    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    io_ready = 1'b0;
    chk_reset_values();
    @(negedge clk);
    chk("rio_after_instr_done", 32'(instr_done), 32'd0);
    chk("rio_after_ram_we", 32'(ram_we), 32'd0);
    chk("rio_after_io_valid", 32'(io_valid), 32'd0);
    chk("rio_after_pc", 32'(pc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stage3_writeback.md
Name: stage3_writeback

Overview:
Commit stage directly downstream of STAGE2. Consumes STAGE2's results (vw_value, vrw_value, ram_address, alu_is_zero) and performs the architectural side effect selected by the write-back mode:
- RAM store,
- PC jump or conditional branch,
- output-port write with handshake,
- halt.
Owns the program-counter register that feeds STAGE2's pc input and the fetch stage.

Parameters:
PC_RESET, 16'd0, PC value loaded on reset.
PC_STEP, 16'd4, PC increment for sequential (non-taken) flow.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  STAGE2 result valid for the current instruction.
in_ready  output  1  stage can accept a result this cycle.
mblock_s3  input  3  write-back mode, sampled on accept.
vw_value  input  32  ALU result from STAGE2.
vrw_value  input  32  resolved rw operand from STAGE2.
ram_address  input  16  effective address from STAGE2.
alu_is_zero  input  1  ALU zero flag from STAGE2.
pc  output  16  current program counter.
ram_we  output  1  RAM write strobe, one cycle.
ram_waddr  output  16  RAM write address.
ram_wdata  output  32  RAM write data.
io_valid  output  1  output-port write pending.
io_ready  input  1  output device accepts.
io_port  output  8  output port number.
io_data  output  32  output data.
instr_done  output  1  one-cycle pulse per committed instruction.
halted  output  1  high while in HALT.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values: pc=PC_RESET, state=IDLE, in_ready=1, ram_we=0, ram_waddr=0, ram_wdata=0, io_valid=0, io_port=0, io_data=0, instr_done=0, halted=0.
- Reset priority: reset wins over every other event, including mid-IO and HALT. A pending io_valid drops at the reset edge, and no RAM write is issued.
- Accept rule: an instruction is accepted on a rising edge where in_valid && in_ready. Inputs are sampled only on that edge.
- in_ready is 1 only in IDLE.

mblock_s3 encoding (the new PC is committed at the accept edge except where noted):
- 0 NOP: pc+=PC_STEP.
- 1 ST_VW: ram[ram_address]<=vw_value; pc+=PC_STEP.
- 2 ST_VRW: ram[ram_address]<=vrw_value; pc+=PC_STEP.
- 3 JMP: pc<=vw_value[15:0].
- 4 JZ: pc<=alu_is_zero ? vw_value[15:0] : pc+PC_STEP.
- 5 JNZ: pc<=!alu_is_zero ? vw_value[15:0] : pc+PC_STEP.
- 6 OUT: io_port<=ram_address[7:0]; io_data<=vw_value; go to IO. pc is unchanged until the IO handshake completes.
- 7 HALT: go to HALT; pc is unchanged.

PC arithmetic and data widths:
- PC arithmetic is 16-bit modulo 2^16; 16'hFFFC + 4 = 16'h0000.
- Jump targets truncate vw_value to [15:0].
- RAM data is the full 32 bits.

States:
- IDLE: in_ready=1.
  - On accept of modes 0–5: go to COMMIT.
  - On accept of mode 6: go to IO.
  - On accept of mode 7: go to HALT.
- COMMIT (exactly one cycle):
  - in_ready=0; instr_done=1.
  - For modes 1 and 2, ram_we=1 with ram_waddr/ram_wdata stable.
  - Next state is IDLE.
  - Throughput is 1 instruction per 2 cycles.
- IO:
  - io_valid=1; io_port and io_data are held stable until the handshake.
  - On an edge with io_ready=1: io_valid<=0, pc+=PC_STEP, go to COMMIT with ram_we=0.
  - io_ready asserted while io_valid=0 is ignored.
- HALT: halted=1, in_ready=0. Only reset exits.

Pulse rules:
- ram_we and instr_done are never high for two consecutive cycles.
- ram_waddr and ram_wdata hold their last values when ram_we=0.

Decomposition:
- Shared package:
  - mblock_s3 encodings MB3_NOP..MB3_HALT (3-bit localparams),
  - state encoding (IDLE, COMMIT, IO, HALT),
  - default PC_STEP.
- Sub-module stage3_pc_next (combinational): inputs pc, mode, alu_is_zero, vw_value[15:0]; output next_pc. Reused by the fetch stage for branch prediction later.

Test Plan:
- Reset with PC_RESET=0, then in_valid=1, mode=1, ram_address=20, vw_value=1099 → the cycle after accept has ram_we=1, ram_waddr=20, ram_wdata=1099, instr_done=1; pc=4; in_ready back to 1 one cycle later.
- pc=84, mode=4, alu_is_zero=1, vw_value=32'h0001_0200 → pc=16'h0200. Repeat with alu_is_zero=0 → pc=88. Mode 5 gives the inverse results.
- mode=6, ram_address=16'h0107, vw_value=42, io_ready held 0 for 3 cycles → io_valid=1, io_port=7, io_data=42 stable, pc unchanged, in_ready=0. Raise io_ready → io_valid falls; pc+=4; one instr_done pulse.
- pc=16'hFFFC, mode=0 → pc=16'h0000 (wrap). mode=2 with vrw_value=99, ram_address=1000 → ram_wdata=99, ram_waddr=1000.
- mode=7 → halted=1 and in_ready=0 indefinitely; further in_valid pulses change nothing. Reset → all outputs return to reset values.
- Assert reset during IO with io_valid=1 and in_valid=1 on the same edge → io_valid=0, pc=PC_RESET, no instr_done and no ram_we at or after that edge.
